// File: rtl/adc_trig_capture.sv
// adc_trig_capture: decimated, armed level/edge trigger capture into a
// circular buffer with trigger-aligned valid/ready readout. Opt: ADC_TRIG_OTR_BLANK_EN
module adc_trig_capture #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int PRE_DEPTH = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] DIN,
    input  logic          OTR_IN,
    input  logic          ARM,
    input  logic          FORCE_TRIG,
    input  logic [DW-1:0] TRIG_LEVEL,
    input  logic          TRIG_EDGE,
    input  logic [7:0]    DECIM,
    input  logic          RD_READY,
    output logic          RD_VALID,
    output logic [DW-1:0] RD_DATA,
    output logic          RD_LAST,
    output logic          BUSY,
    output logic          DONE,
    output logic          OTR_SEEN
);
    localparam int DEPTH  = 1 << AW;
    localparam int POST_N = DEPTH - PRE_DEPTH - 1;
    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEPTH - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_DEPTH);
    localparam logic [AW:0]   N_ALL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   N_LAST    = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   ONE_F     = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT, S_POST, S_READ
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    decim_q, decim_d, dcnt_q, dcnt_d;
    logic          edge_q, edge_d;
    logic [DW-1:0] level_q, level_d, prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d, fpend_q, fpend_d;
    logic [AW-1:0] wptr_q, wptr_d, cnt_q, cnt_d;
    logic [AW-1:0] taddr_q, taddr_d, raddr_q, raddr_d;
    logic [AW:0]   fcnt_q, fcnt_d;
    logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          done_q, done_d, otr_q, otr_d;
    logic [DW-1:0] mem [DEPTH];

    logic capturing, strobe, we, cur_ok;
    logic rise_hit, fall_hit, level_hit, fetch, xfer;

    assign capturing = (state_q == S_PRE) || (state_q == S_WAIT)
                    || (state_q == S_POST);
    assign strobe    = capturing && (dcnt_q == decim_q);
    assign rise_hit  = (prev_q < level_q) && (DIN >= level_q);
    assign fall_hit  = (prev_q >= level_q) && (DIN < level_q);
`ifdef ADC_TRIG_OTR_BLANK_EN
    assign cur_ok    = !OTR_IN;
`else
    assign cur_ok    = 1'b1;
`endif
    assign level_hit = prev_vld_q && cur_ok && (edge_q ? fall_hit : rise_hit);
    assign fetch     = (fcnt_q != N_ALL) && (!rd_valid_q || RD_READY);
    assign xfer      = rd_valid_q && RD_READY;

    // Next-state: decimation, buffer writes, trigger search, readout.
    always_comb begin
        state_d    = state_q;
        decim_d    = decim_q;
        dcnt_d     = dcnt_q;
        edge_d     = edge_q;
        level_d    = level_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        fpend_d    = fpend_q;
        wptr_d     = wptr_q;
        cnt_d      = cnt_q;
        taddr_d    = taddr_q;
        raddr_d    = raddr_q;
        fcnt_d     = fcnt_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        otr_d      = otr_q;
        we         = 1'b0;
        if (capturing) begin
            dcnt_d = strobe ? 8'd0 : dcnt_q + 8'd1;
        end
        if (strobe) begin
            we         = 1'b1;
            wptr_d     = wptr_q + ONE_A;
            prev_d     = DIN;
            prev_vld_d = cur_ok;
            if (OTR_IN) otr_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (ARM) begin
                    state_d    = S_PRE;
                    decim_d    = DECIM;
                    edge_d     = TRIG_EDGE;
                    level_d    = TRIG_LEVEL;
                    dcnt_d     = 8'd0;
                    otr_d      = 1'b0;
                    prev_vld_d = 1'b0;
                    fpend_d    = 1'b0;
                    cnt_d      = '0;
                    wptr_d     = '0;
                end
            end
            S_PRE: begin
                if (strobe) begin
                    cnt_d = cnt_q + ONE_A;
                    if (cnt_q == PRE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (FORCE_TRIG) fpend_d = 1'b1;
                if (strobe && (fpend_q || level_hit)) begin
                    fpend_d = 1'b0;
                    taddr_d = wptr_q;
                    cnt_d   = '0;
                    state_d = S_POST;
                end
            end
            S_POST: begin
                if (strobe) begin
                    cnt_d = cnt_q + ONE_A;
                    if (cnt_q == POST_LAST) begin
                        state_d = S_READ;
                        raddr_d = taddr_q - PRE_OFS;
                        fcnt_d  = '0;
                    end
                end
            end
            S_READ: begin
                if (fetch) begin
                    rd_data_d  = mem[raddr_q];
                    rd_valid_d = 1'b1;
                    rd_last_d  = (fcnt_q == N_LAST);
                    raddr_d    = raddr_q + ONE_A;
                    fcnt_d     = fcnt_q + ONE_F;
                end else if (xfer && rd_last_q) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and readout registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            decim_q    <= '0;
            dcnt_q     <= '0;
            edge_q     <= 1'b0;
            level_q    <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            fpend_q    <= 1'b0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            taddr_q    <= '0;
            raddr_q    <= '0;
            fcnt_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            otr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            decim_q    <= decim_d;
            dcnt_q     <= dcnt_d;
            edge_q     <= edge_d;
            level_q    <= level_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            fpend_q    <= fpend_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            taddr_q    <= taddr_d;
            raddr_q    <= raddr_d;
            fcnt_q     <= fcnt_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            otr_q      <= otr_d;
        end
    end

    // Sample buffer write port; storage itself needs no reset.
    always_ff @(posedge CLK) begin
        if (we) mem[wptr_q] <= DIN;
    end

    assign RD_VALID = rd_valid_q;
    assign RD_DATA  = rd_data_q;
    assign RD_LAST  = rd_last_q;
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;
    assign OTR_SEEN = otr_q;

endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: randomized capture runs checked against a
// sample-list model of decimation, trigger search and readout order.
`timescale 1ns/1ps
module tb_adc_trig_capture;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int PRE   = 32;
    localparam int POSTN = DEPTH - PRE - 1;
    localparam int NC    = 4096;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic          OTR_IN = 1'b0;
    logic          ARM = 1'b0;
    logic          FORCE_TRIG = 1'b0;
    logic [DW-1:0] TRIG_LEVEL = '0;
    logic          TRIG_EDGE = 1'b0;
    logic [7:0]    DECIM = '0;
    logic          RD_READY = 1'b0;
    logic          RD_VALID;
    logic [DW-1:0] RD_DATA;
    logic          RD_LAST;
    logic          BUSY;
    logic          DONE;
    logic          OTR_SEEN;

    always #5 CLK = ~CLK;

    adc_trig_capture #(.DW(DW), .AW(AW), .PRE_DEPTH(PRE)) dut (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .OTR_IN(OTR_IN),
        .ARM(ARM), .FORCE_TRIG(FORCE_TRIG), .TRIG_LEVEL(TRIG_LEVEL),
        .TRIG_EDGE(TRIG_EDGE), .DECIM(DECIM), .RD_READY(RD_READY),
        .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
        .BUSY(BUSY), .DONE(DONE), .OTR_SEEN(OTR_SEEN)
    );

    logic [7:0] din_a [NC];
    logic       otr_a [NC];
    logic       frc_a [NC];
    logic       arm_a [NC];
    logic [7:0] exp_d [DEPTH];
    logic       exp_otr;
    int         exp_t;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit cap_on = 1'b0;
    int cap_id = 0;
    int done_id = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Per-cycle compare of the readout stream against the model list.
    int n = 0;
    int seen_id = 0;
    bit stall = 1'b0;
    bit dnext = 1'b0;
    logic [7:0] hd;
    logic hl;
    always @(negedge CLK) begin
        if (!chk_en) begin
            stall = 1'b0;
            dnext = 1'b0;
        end else begin
            if (cap_id != seen_id) begin
                seen_id = cap_id;
                n = 0;
                stall = 1'b0;
                dnext = 1'b0;
            end
            chk("busy", 32'(BUSY), 32'(cap_on && n < DEPTH));
            chk("done", 32'(DONE), 32'(dnext));
            if (dnext) begin
                chk("valid_after_done", 32'(RD_VALID), 0);
                done_id = cap_id;
                dnext = 1'b0;
            end
            if (stall) begin
                chk("stall_valid", 32'(RD_VALID), 1);
                chk("stall_data", 32'(RD_DATA), 32'(hd));
                chk("stall_last", 32'(RD_LAST), 32'(hl));
            end
            if (RD_VALID === 1'b1 && RD_READY === 1'b1) begin
                if (n >= DEPTH) begin
                    chk("extra_xfer", 32'(n), DEPTH - 1);
                end else begin
                    chk("rd_data", 32'(RD_DATA), 32'(exp_d[n]));
                    chk("rd_last", 32'(RD_LAST), 32'(n == DEPTH - 1));
                    chk("otr_seen", 32'(OTR_SEEN), 32'(exp_otr));
                    n++;
                    if (n == DEPTH) dnext = 1'b1;
                end
            end
            stall = (RD_VALID === 1'b1) && (RD_READY !== 1'b1);
            hd = RD_DATA;
            hl = RD_LAST;
        end
    end

    task automatic clear_stim();
        for (int k = 0; k < NC; k++) begin
            din_a[k] = '0;
            otr_a[k] = 1'b0;
            frc_a[k] = 1'b0;
            arm_a[k] = 1'b0;
        end
    endtask

    // Model: list of kept samples, first trigger index, readout window.
    task automatic build_model(input int d, input bit edg,
                               input logic [7:0] lvl);
        logic [7:0] sv[$];
        logic so[$];
        bit pend, hit;
        int lo;
        sv.delete();
        so.delete();
        for (int c = d + 1; c < NC; c += d + 1) begin
            sv.push_back(din_a[c]);
            so.push_back(otr_a[c]);
        end
        exp_t = -1;
        pend = 1'b0;
        for (int j = PRE; j < sv.size() && exp_t < 0; j++) begin
            lo = (j == PRE) ? j * (d + 1) + 1 : j * (d + 1);
            for (int c = lo; c < (j + 1) * (d + 1); c++)
                if (frc_a[c]) pend = 1'b1;
            if (edg) hit = (sv[j-1] >= lvl) && (sv[j] < lvl);
            else     hit = (sv[j-1] < lvl) && (sv[j] >= lvl);
`ifdef ADC_TRIG_OTR_BLANK_EN
            if (so[j] || so[j-1]) hit = 1'b0;
`endif
            if (pend || hit) exp_t = j;
        end
        chk("model_window", 32'(exp_t >= PRE && exp_t + POSTN < sv.size()), 1);
        exp_otr = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_d[i] = '0;
        if (exp_t >= PRE && exp_t + POSTN < sv.size()) begin
            for (int i = 0; i < DEPTH; i++) exp_d[i] = sv[exp_t - PRE + i];
            for (int i = 0; i <= exp_t + POSTN; i++)
                if (so[i]) exp_otr = 1'b1;
        end
    endtask

    task automatic do_abort();
        chk_en = 1'b0;
        chk("pre_abort_busy", 32'(BUSY), 1);
        chk("pre_abort_otr", 32'(OTR_SEEN), 1);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_outs", {26'd0, RD_VALID, RD_LAST, BUSY, DONE, OTR_SEEN, 1'b0}, 0);
        chk("rst_data", 32'(RD_DATA), 0);
        ARM = 1'b0;
        FORCE_TRIG = 1'b0;
        cap_on = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("post_rst_idle", {30'd0, BUSY, DONE}, 0);
        end
        @(posedge CLK);
        #1 chk_en = 1'b1;
    endtask

    task automatic run(input int d, input bit edg, input logic [7:0] lvl,
                       input int rdy_pct, input int abort_at,
                       input int arm_ofs);
        int k, ai;
        build_model(d, edg, lvl);
        ai = (exp_t + 1) * (d + 1) + arm_ofs;
        if (arm_ofs > 0 && ai < NC) arm_a[ai] = 1'b1;
        cap_id++;
        k = 0;
        while (k < NC + 8 * DEPTH && done_id != cap_id) begin
            @(posedge CLK);
            #1;
            if (k == abort_at) begin
                do_abort();
                return;
            end
            if (k == 1) cap_on = 1'b1;
            DECIM      = 8'(d);
            TRIG_EDGE  = edg;
            TRIG_LEVEL = lvl;
            ARM        = (k == 0) || (k < NC && arm_a[k]);
            DIN        = (k < NC) ? din_a[k] : 8'($urandom);
            OTR_IN     = (k < NC) ? otr_a[k] : 1'b0;
            FORCE_TRIG = (k < NC) ? frc_a[k] : 1'b0;
            RD_READY   = ($urandom_range(99) < rdy_pct);
            k++;
        end
        cap_on = 1'b0;
        chk("capture_done", 32'(done_id == cap_id), 1);
        @(posedge CLK);
        #1;
        ARM = 1'b0;
        FORCE_TRIG = 1'b0;
        RD_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic stim_ramp();
        clear_stim();
        for (int k = 0; k < NC; k++) din_a[k] = 8'(k - 1);
    endtask

    initial begin
        int v;
        #2;
        chk("reset_outs", {26'd0, RD_VALID, RD_LAST, BUSY, DONE, OTR_SEEN, 1'b0}, 0);
        chk("reset_data", 32'(RD_DATA), 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        chk_en = 1'b1;
        @(posedge CLK);
        #1;

        stim_ramp();
        build_model(0, 1'b0, 8'h80);
        chk("pin_t1_trig", 32'(exp_t), 128);
        chk("pin_t1_first", 32'(exp_d[0]), 32'h60);
        chk("pin_t1_idx32", 32'(exp_d[32]), 32'h80);
        chk("pin_t1_last", 32'(exp_d[255]), 32'h5F);
        run(0, 1'b0, 8'h80, 100, -1, 0);

        stim_ramp();
        otr_a[129] = 1'b1;
        build_model(0, 1'b0, 8'h80);
`ifdef ADC_TRIG_OTR_BLANK_EN
        chk("pin_otr_trig", 32'(exp_t), 384);
`else
        chk("pin_otr_trig", 32'(exp_t), 128);
`endif
        chk("pin_otr_seen", 32'(exp_otr), 1);
        run(0, 1'b0, 8'h80, 60, -1, 0);

        clear_stim();
        for (int k = 0; k < NC; k++) din_a[k] = 8'(k);
        build_model(3, 1'b0, 8'h80);
        chk("pin_t3_trig", 32'(exp_t), 95);
        chk("pin_t3_first", 32'(exp_d[0]), 32'h00);
        chk("pin_t3_step", 32'(exp_d[1]), 32'h04);
        chk("pin_t3_idx32", 32'(exp_d[32]), 32'h80);
        run(3, 1'b0, 8'h80, 70, -1, 5);

        clear_stim();
        din_a[0] = 8'h20;
        for (int k = 1; k < NC; k++)
            din_a[k] = (k <= 40) ? 8'h10 : 8'($urandom_range(0, 63));
        frc_a[100] = 1'b1;
        build_model(0, 1'b1, 8'h40);
        chk("pin_force_trig", 32'(exp_t), 100);
        chk("pin_force_idx32", 32'(exp_d[32]), 32'(din_a[101]));
        run(0, 1'b1, 8'h40, 50, -1, 0);

        for (int r = 0; r < 3; r++) begin
            int d;
            clear_stim();
            d = $urandom_range(0, 2);
            v = $urandom_range(0, 255);
            for (int k = 0; k < NC; k++) begin
                v = v + $urandom_range(0, 16) - 8;
                din_a[k] = 8'(v);
                otr_a[k] = ($urandom_range(63) == 0);
            end
            frc_a[250 * (d + 1)] = 1'b1;
            run(d, 1'($urandom_range(1)), 8'($urandom_range(0, 255)),
                50, -1, 0);
        end

        stim_ramp();
        otr_a[50] = 1'b1;
        run(0, 1'b0, 8'h80, 100, 200, 0);

        stim_ramp();
        run(0, 1'b0, 8'h80, 80, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
